// File: rtl/xmit_prio_sched.sv
// Transmit frame scheduler: hi/lo control-block queues, a strict-priority arbiter
// with a starvation guard, per-byte read strobes to the hi/lo data buffers, and
// the inter-frame gap.
module xmit_prio_sched #(
  parameter int CDEPTH     = 4,
  parameter int STARVE_LIM = 4,
  parameter int IFG        = 12,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [23:0] f_ctrl_in,
  input  logic        f_rec_frame_valid,
  input  logic        f_hi_priority,
  input  logic        tx_ready,
  output logic        rd_hi_en,
  output logic        rd_lo_en,
  output logic        tx_start,
  output logic        tx_last,
  output logic        tx_sel,
  output logic [11:0] tx_meta,
  output logic        tx_busy,
  output logic        m_discard_en
);

  localparam int AW = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int GW = (IFG > 1) ? $clog2(IFG + 1) : 1;

  localparam logic [11:0]   LEN_MIN   = 12'(MIN_LEN);
  localparam logic [11:0]   LEN_MAX   = 12'(MAX_LEN);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CDEPTH);
  localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIM);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IFG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nstate;

  // Control-block storage; contents need no reset because occupancy gates every read.
  logic [23:0]   r_hi_mem [CDEPTH];
  logic [23:0]   r_lo_mem [CDEPTH];
  logic [AW-1:0] r_hi_wr, r_hi_rd, r_lo_wr, r_lo_rd;
  logic [CW-1:0] r_hi_cnt, r_lo_cnt;

  logic          r_sel;
  logic [11:0]   r_meta;
  logic [11:0]   r_len;
  logic [11:0]   r_bcnt;
  logic          r_first;
  logic [GW-1:0] r_gap;
  logic [SW-1:0] r_starve;
  logic          r_discard;

  logic        w_hi_empty, w_lo_empty, w_hi_full, w_lo_full;
  logic        w_len_ok;
  logic        w_pick, w_pick_hi, w_pop_hi, w_pop_lo;
  logic        w_push_hi, w_push_lo, w_drop;
  logic [23:0] w_head;

  assign w_hi_empty = (r_hi_cnt == '0);
  assign w_lo_empty = (r_lo_cnt == '0);
  assign w_hi_full  = (r_hi_cnt == CNT_FULL);
  assign w_lo_full  = (r_lo_cnt == CNT_FULL);

  assign w_len_ok = (f_ctrl_in[11:0] >= LEN_MIN) && (f_ctrl_in[11:0] <= LEN_MAX);

  // Arbitration happens only in IDLE; hi wins unless lo has waited STARVE_LIM hi frames.
  assign w_pick    = (r_state == S_IDLE) && (!w_hi_empty || !w_lo_empty);
  assign w_pick_hi = !w_hi_empty && (w_lo_empty || (r_starve < STARVE_MX));
  assign w_pop_hi  = w_pick && w_pick_hi;
  assign w_pop_lo  = w_pick && !w_pick_hi;
  assign w_head    = w_pick_hi ? r_hi_mem[r_hi_rd] : r_lo_mem[r_lo_rd];

  // A full queue still accepts when its head is being popped in the same cycle.
  assign w_push_hi = f_rec_frame_valid &&  f_hi_priority && w_len_ok && (!w_hi_full || w_pop_hi);
  assign w_push_lo = f_rec_frame_valid && !f_hi_priority && w_len_ok && (!w_lo_full || w_pop_lo);
  assign w_drop    = f_rec_frame_valid && !(w_push_hi || w_push_lo);

  assign tx_sel       = r_sel;
  assign tx_meta      = r_meta;
  assign tx_busy      = (r_state != S_IDLE);
  assign m_discard_en = r_discard;

  // Write accepted control blocks into their class queue.
  always_ff @(posedge clk_sys) begin
    if (w_push_hi) r_hi_mem[r_hi_wr] <= f_ctrl_in;
    if (w_push_lo) r_lo_mem[r_lo_wr] <= f_ctrl_in;
  end

  // Hi queue pointers and occupancy.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_hi_wr  <= '0;
      r_hi_rd  <= '0;
      r_hi_cnt <= '0;
    end else begin
      if (w_push_hi) r_hi_wr <= r_hi_wr + AW'(1);
      if (w_pop_hi)  r_hi_rd <= r_hi_rd + AW'(1);
      if (w_push_hi && !w_pop_hi)      r_hi_cnt <= r_hi_cnt + CW'(1);
      else if (!w_push_hi && w_pop_hi) r_hi_cnt <= r_hi_cnt - CW'(1);
    end
  end

  // Lo queue pointers and occupancy.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_lo_wr  <= '0;
      r_lo_rd  <= '0;
      r_lo_cnt <= '0;
    end else begin
      if (w_push_lo) r_lo_wr <= r_lo_wr + AW'(1);
      if (w_pop_lo)  r_lo_rd <= r_lo_rd + AW'(1);
      if (w_push_lo && !w_pop_lo)      r_lo_cnt <= r_lo_cnt + CW'(1);
      else if (!w_push_lo && w_pop_lo) r_lo_cnt <= r_lo_cnt - CW'(1);
    end
  end

  // Discard pulse is reported the cycle after the rejected strobe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_discard <= 1'b0;
    else       r_discard <= w_drop;
  end

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  // Next-state and per-byte strobe generation.
  always_comb begin
    w_nstate = r_state;
    rd_hi_en = 1'b0;
    rd_lo_en = 1'b0;
    tx_start = 1'b0;
    tx_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick) w_nstate = S_LOAD;
      end
      S_LOAD: begin
        w_nstate = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          rd_hi_en = r_sel;
          rd_lo_en = !r_sel;
          tx_start = r_first;
          if (r_bcnt == 12'd1) begin
            tx_last  = 1'b1;
            w_nstate = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Frame context latched at pick, byte countdown in SEND, gap count in GAP.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_sel    <= 1'b0;
      r_meta   <= '0;
      r_len    <= '0;
      r_bcnt   <= '0;
      r_first  <= 1'b0;
      r_gap    <= '0;
      r_starve <= '0;
    end else begin
      if (w_pick) begin
        r_sel  <= w_pick_hi;
        r_meta <= w_head[23:12];
        r_len  <= w_head[11:0];
        if (w_pick_hi && !w_lo_empty) begin
          if (r_starve != STARVE_MX) r_starve <= r_starve + SW'(1);
        end else begin
          r_starve <= '0;
        end
      end
      if (r_state == S_LOAD) begin
        r_bcnt  <= r_len;
        r_first <= 1'b1;
      end
      if ((r_state == S_SEND) && tx_ready) begin
        r_bcnt  <= r_bcnt - 12'd1;
        r_first <= 1'b0;
      end
      if (r_state == S_GAP) r_gap <= r_gap + GW'(1);
      else                  r_gap <= '0;
    end
  end

endmodule

// File: tb/tb_xmit_prio_sched.sv
// Bench for xmit_prio_sched: scoreboard of expected frames (class, metadata, length)
// checked byte by byte on the read strobes, plus directed timing sequences.
module tb_xmit_prio_sched;

  localparam int IFG = 12;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [23:0] f_ctrl_in;
  logic        f_rec_frame_valid;
  logic        f_hi_priority;
  logic        tx_ready;
  logic        rd_hi_en, rd_lo_en, tx_start, tx_last, tx_sel, tx_busy, m_discard_en;
  logic [11:0] tx_meta;
  logic [18:0] outs;

  assign outs = {rd_hi_en, rd_lo_en, tx_start, tx_last, tx_sel, tx_meta, tx_busy, m_discard_en};

  xmit_prio_sched #(.CDEPTH(4), .STARVE_LIM(4), .IFG(IFG), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_sys(clk_sys), .reset(reset), .f_ctrl_in(f_ctrl_in),
    .f_rec_frame_valid(f_rec_frame_valid), .f_hi_priority(f_hi_priority), .tx_ready(tx_ready),
    .rd_hi_en(rd_hi_en), .rd_lo_en(rd_lo_en), .tx_start(tx_start), .tx_last(tx_last),
    .tx_sel(tx_sel), .tx_meta(tx_meta), .tx_busy(tx_busy), .m_discard_en(m_discard_en)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic sel; logic [11:0] meta; int len; } frame_t;
  typedef struct { logic hi; int len; logic [11:0] meta; logic drop; } vec_t;

  frame_t exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, longint got, longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
  endfunction

  // Monitor: byte counting, class/metadata per strobe, frame order, inter-frame gap.
  frame_t cur;
  logic   in_frame = 1'b0;
  int     nbytes   = 0;
  logic   gap_act  = 1'b0;
  int     gap_cnt  = 0;

  always @(negedge clk_sys) begin
    if (reset) begin
      in_frame = 1'b0;
      gap_act  = 1'b0;
    end else begin
      if (gap_act) begin
        if (tx_busy) gap_cnt++;
        else begin
          chk("ifg_cycles", gap_cnt, IFG);
          gap_act = 1'b0;
        end
      end
      if (tx_start || tx_last) chk("start_last_has_strobe", rd_hi_en | rd_lo_en, 1);
      if (rd_hi_en || rd_lo_en) begin
        chk("strobe_excl_and_ready", {rd_hi_en & rd_lo_en, tx_ready}, 2'b01);
        if (tx_start) begin
          chk("start_not_mid_frame", in_frame, 0);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          else                  cur = '{1'b0, 12'hFFF, -1};
          in_frame = 1'b1;
          nbytes   = 0;
        end
        chk("strobe_in_frame", in_frame, 1);
        if (in_frame) begin
          nbytes++;
          chk("strobe_class_meta", {rd_hi_en, tx_sel, tx_meta}, {cur.sel, cur.sel, cur.meta});
          if (tx_last) begin
            chk("frame_len", nbytes, cur.len);
            in_frame = 1'b0;
            gap_act  = 1'b1;
            gap_cnt  = 0;
          end else begin
            chk("last_not_overdue", nbytes < cur.len, 1);
          end
        end
      end
    end
  end

  task automatic send_ctrl(input logic hi, input int len, input logic [11:0] meta,
                           input logic exp_drop, input logic push_sb);
    f_ctrl_in         = {meta, 12'(len)};
    f_hi_priority     = hi;
    f_rec_frame_valid = 1'b1;
    if (push_sb && !exp_drop) exp_q.push_back('{hi, meta, len});
    @(negedge clk_sys);
    f_rec_frame_valid = 1'b0;
    chk("discard_pulse", m_discard_en, exp_drop);
  endtask

  // tx_ready feeds the strobes combinationally, so it changes just after a rising edge.
  task automatic set_ready(input logic v);
    @(posedge clk_sys);
    #1 tx_ready = v;
    @(negedge clk_sys);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || in_frame || gap_act) && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    chk("drain_in_budget", k < budget, 1);
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!tx_start && k < budget);
    chk("start_in_budget", tx_start, 1);
  endtask

  // Strobe into an idle, empty scheduler and check pick / load / first byte timing.
  task automatic latency_frame(input logic [11:0] meta);
    send_ctrl(1'b0, 64, meta, 1'b0, 1'b1);
    chk("lat_n1_idle", {tx_busy, tx_start}, 2'b00);
    @(negedge clk_sys);
    chk("lat_n2_load", {tx_busy, tx_start}, 2'b10);
    @(negedge clk_sys);
    chk("lat_n3_start", {tx_busy, tx_start, rd_lo_en}, 3'b111);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[10];
    logic any_out;
    int   k;

    vt = '{'{1'b0,   63, 12'h501, 1'b1},
           '{1'b0,   64, 12'h502, 1'b0},
           '{1'b0, 1519, 12'h503, 1'b1},
           '{1'b0, 1518, 12'h504, 1'b0},
           '{1'b1, 2000, 12'h505, 1'b1},
           '{1'b0,    0, 12'h506, 1'b1},
           '{1'b0, 4095, 12'h507, 1'b1},
           '{1'b1,   63, 12'h508, 1'b1},
           '{1'b0,   65, 12'h509, 1'b0},
           '{1'b0,   32, 12'h50A, 1'b1}};

    reset = 1'b1; f_ctrl_in = '0; f_rec_frame_valid = 1'b0; f_hi_priority = 1'b0; tx_ready = 1'b0;
    #1 chk("reset_outputs", outs, 0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    tx_ready = 1'b1;

    // Reset with no strobes: everything stays low.
    any_out = 1'b0;
    repeat (20) begin
      @(negedge clk_sys);
      any_out = any_out | (|outs);
    end
    chk("idle_outputs_zero", any_out, 0);

    // Single lo frame: latency, 64 strobes, gap.
    latency_frame(12'h0A1);
    wait_drain(300);
    chk("busy_falls_after_gap", tx_busy, 0);

    // Lo then hi queued behind a frame in flight: hi goes first.
    send_ctrl(1'b0, 64, 12'h0F0, 1'b0, 1'b1);
    wait_start(10);
    exp_q.push_back('{1'b1, 12'h3B1, 100});
    exp_q.push_back('{1'b0, 12'h3A1, 64});
    send_ctrl(1'b0, 64, 12'h3A1, 1'b0, 1'b0);
    send_ctrl(1'b1, 100, 12'h3B1, 1'b0, 1'b0);
    wait_drain(1000);

    // Starvation guard: 4 hi, then the waiting lo, then the later hi frames.
    send_ctrl(1'b0, 64, 12'h400, 1'b0, 1'b1);
    wait_start(10);
    for (int i = 1; i <= 4; i++) exp_q.push_back('{1'b1, 12'(12'h410 + i), 64});
    exp_q.push_back('{1'b0, 12'h420, 64});
    exp_q.push_back('{1'b1, 12'h415, 64});
    exp_q.push_back('{1'b1, 12'h416, 64});
    for (int i = 1; i <= 4; i++) send_ctrl(1'b1, 64, 12'(12'h410 + i), 1'b0, 1'b0);
    send_ctrl(1'b0, 64, 12'h420, 1'b0, 1'b0);
    wait_start(200);
    send_ctrl(1'b1, 64, 12'h415, 1'b0, 1'b0);
    wait_start(200);
    send_ctrl(1'b1, 64, 12'h416, 1'b0, 1'b0);
    wait_drain(2000);

    // Length limits and class routing from the vector table.
    for (int i = 0; i < 10; i++) send_ctrl(vt[i].hi, vt[i].len, vt[i].meta, vt[i].drop, 1'b1);
    wait_drain(5000);

    // Full hi queue: stall the sender, fill, overflow and bad lengths are dropped.
    set_ready(1'b0);
    for (int i = 1; i <= 5; i++) send_ctrl(1'b1, 64, 12'(12'h600 + i), 1'b0, 1'b1);
    send_ctrl(1'b1, 64, 12'h606, 1'b1, 1'b1);
    send_ctrl(1'b1, 32, 12'h607, 1'b1, 1'b1);
    send_ctrl(1'b1, 2000, 12'h608, 1'b1, 1'b1);
    send_ctrl(1'b0, 2000, 12'h609, 1'b1, 1'b1);
    repeat (4) @(negedge clk_sys);
    chk("stalled_in_send", {tx_busy, rd_hi_en, rd_lo_en}, 3'b100);
    set_ready(1'b1);
    k = 0;
    while (tx_busy && k < 500) begin
      @(negedge clk_sys);
      k++;
    end
    chk("pick_cycle_reached", tx_busy, 0);
    send_ctrl(1'b1, 64, 12'h60A, 1'b0, 1'b1);
    wait_drain(3000);

    // tx_ready toggling every cycle during a 64-byte frame.
    send_ctrl(1'b0, 64, 12'h701, 1'b0, 1'b1);
    k = 0;
    while ((exp_q.size() != 0 || in_frame || gap_act) && k < 600) begin
      @(posedge clk_sys);
      #1 tx_ready = ~tx_ready;
      @(negedge clk_sys);
      k++;
    end
    chk("toggle_frame_done", k < 600, 1);
    set_ready(1'b1);

    // Reset in the middle of SEND with more frames queued.
    send_ctrl(1'b0, 200, 12'h801, 1'b0, 1'b1);
    wait_start(10);
    send_ctrl(1'b1, 64, 12'h802, 1'b0, 1'b0);
    send_ctrl(1'b0, 64, 12'h803, 1'b0, 1'b0);
    repeat (20) @(negedge clk_sys);
    reset = 1'b1;
    #1 chk("reset_midframe_outputs", outs, 0);
    exp_q.delete();
    repeat (2) @(negedge clk_sys);
    chk("held_reset_outputs", outs, 0);
    reset = 1'b0;
    any_out = 1'b0;
    repeat (30) begin
      @(negedge clk_sys);
      any_out = any_out | (|outs);
    end
    chk("queues_empty_after_reset", any_out, 0);
    latency_frame(12'h901);
    wait_drain(300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
